// File: rtl/barrett_pkg.sv
// Shared constants and elaboration helpers for the Barrett reduction pipeline.
package barrett_pkg;

   localparam int Q_DEFAULT = 3533;
   localparam int Q_KYBER   = 3329;

   function automatic int barrett_k(input int q);
      return $clog2(q);
   endfunction

   // floor(2^(2k)/q), evaluated in 64 bits so k up to 16 cannot overflow
   function automatic int barrett_mu(input int q, input int k);
      longint num;
      num = longint'(1) << (2 * k);
      return int'(num / longint'(q));
   endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Final correction: brings a value in [0, 3Q) into [0, Q) with two subtract terms.
module barrett_cond_sub
   import barrett_pkg::*;
#(
   parameter int Q = Q_DEFAULT,
   parameter int K = barrett_k(Q)
) (
   input  logic [K+1:0] r_in,
   output logic [K-1:0] r_out
);

   localparam int R_W = K + 2;
   localparam logic [R_W-1:0] Q1 = R_W'(Q);
   localparam logic [R_W-1:0] Q2 = R_W'(2 * Q);

   always_comb begin
      r_out = K'(r_in);
      if (r_in >= Q2) begin
         r_out = K'(r_in - Q2);
      end else if (r_in >= Q1) begin
         r_out = K'(r_in - Q1);
      end
   end

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Three-stage pipelined Barrett reducer, dout_r = din_a mod Q, valid/ready stream.
// All stages advance together whenever the output slot is free or being drained.
module barrett_reduce_pipe
   import barrett_pkg::*;
#(
   parameter int Q     = Q_DEFAULT,
   parameter int TAG_W = 4,
   localparam int K    = barrett_k(Q),
   localparam int IN_W = 2 * K
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  din_a,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     dout_r,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   localparam int MU   = barrett_mu(Q, K);
   localparam int QH_W = 2 * K + 1;
   localparam int T_W  = K + 1;
   localparam int R_W  = K + 2;

   if (Q < 3 || Q >= 65536) begin : g_bad_q
      $error("barrett_reduce_pipe: Q must satisfy 3 <= Q < 65536");
   end

   logic             advance;
   logic             v1, v2, v3;
   logic [IN_W-1:0]  a1;
   logic [QH_W-1:0]  qh;
   logic [R_W-1:0]   r2;
   logic [TAG_W-1:0] tag1, tag2;

   logic [K-1:0]     hi;
   logic [QH_W-1:0]  qh_n;
   logic [T_W-1:0]   t;
   logic [IN_W-1:0]  tq;
   logic [R_W-1:0]   r2_n;
   logic [K-1:0]     r3;

   assign advance   = !v3 || out_ready;
   assign in_ready  = advance;
   assign out_valid = v3;
   assign busy      = v1 | v2 | v3;

   assign hi   = K'(din_a >> K);
   assign qh_n = QH_W'(hi) * QH_W'(MU);

   // quotient estimate is at most 2 short, so the difference fits K+2 bits
   assign t    = T_W'(qh >> K);
   assign tq   = IN_W'(t) * IN_W'(Q);
   assign r2_n = R_W'(a1 - tq);

   barrett_cond_sub #(
      .Q (Q),
      .K (K)
   ) u_cond_sub (
      .r_in  (r2),
      .r_out (r3)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1      <= 1'b0;
         v2      <= 1'b0;
         v3      <= 1'b0;
         a1      <= '0;
         qh      <= '0;
         r2      <= '0;
         tag1    <= '0;
         tag2    <= '0;
         dout_r  <= '0;
         out_tag <= '0;
      end else if (advance) begin
         v1      <= in_valid;
         a1      <= din_a;
         qh      <= qh_n;
         tag1    <= in_tag;
         v2      <= v1;
         r2      <= r2_n;
         tag2    <= tag1;
         v3      <= v2;
         dout_r  <= r3;
         out_tag <= tag2;
      end
   end

endmodule
